// File: rtl/rl_md_pkg.sv
// Shared types and defaults for the RL MD pair-generation path.
//   pos_t            : packed {z,y,x} fp32 position word
//   pair_gen_state_e : pair generator FSM states
//   DEF_*            : default widths and counts used by rl_pair_gen
package rl_md_pkg;

    localparam int DEF_DATA_WIDTH        = 32;
    localparam int DEF_PARTICLE_ID_WIDTH = 7;
    localparam int DEF_NUM_FILTER        = 7;
    localparam int DEF_DRAIN_GUARD       = 4;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] z;
        logic [DEF_DATA_WIDTH-1:0] y;
        logic [DEF_DATA_WIDTH-1:0] x;
    } pos_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } pair_gen_state_e;

endpackage

// File: rtl/rl_ref_slot_bank.sv
// Reference slot bank: one {z,y,x} register per filter slot plus the
// slot-valid mask for the current reference group.
//   clk, rst   : clock, async active-low reset
//   mask_ld    : load slot_valid from mask_in (once per group)
//   mask_in    : which slots hold a real home particle this group
//   ld_en      : per-slot capture enable for ld_pos
//   ld_pos     : {z,y,x} home position being captured
//   ref_x/y/z  : per-slot reference coordinates
//   slot_valid : per-slot valid mask
module rl_ref_slot_bank #(
    parameter int NUM_FILTER = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mask_ld,
    input  logic [NUM_FILTER-1:0]                mask_in,
    input  logic [NUM_FILTER-1:0]                ld_en,
    input  logic [3*DATA_WIDTH-1:0]              ld_pos,
    output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_x,
    output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_y,
    output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_z,
    output logic [NUM_FILTER-1:0]                slot_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            slot_valid <= '0;
        else if (mask_ld)
            slot_valid <= mask_in;
    end

    // Unused slots in a short group keep stale data; slot_valid masks them.
    for (genvar k = 0; k < NUM_FILTER; k++) begin : g_slot
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ref_x[k] <= '0;
                ref_y[k] <= '0;
                ref_z[k] <= '0;
            end else if (ld_en[k]) begin
                ref_x[k] <= ld_pos[0*DATA_WIDTH +: DATA_WIDTH];
                ref_y[k] <= ld_pos[1*DATA_WIDTH +: DATA_WIDTH];
                ref_z[k] <= ld_pos[2*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rl_pair_gen.sv
// Pair generator feeding the RL LJ evaluation unit.
// Loads up to NUM_FILTER home particles as a reference group, streams every
// neighbour-cell particle against that group, then waits for the filter
// buffers to drain before moving to the next group.
//   clk, rst                     : clock, async active-low reset
//   start, phase                 : pass start pulse; 0 = home/home (half shell)
//   home_count, nb_count         : particle counts, sampled at start
//   home_rd_* / nb_rd_*          : position memory reads, data 1 cycle after en
//   back_pressure                : per-filter stop
//   all_buffer_empty             : filter buffers drained
//   pair_valid                   : per-slot valid for the presented pair
//   ref_particle_id              : group base id (slot k = base+k)
//   nb_particle_id, nb_position  : presented neighbour
//   ref_x/y/z                    : reference slot positions
//   busy, done                   : pass in progress / 1-cycle completion pulse
module rl_pair_gen
    import rl_md_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int PARTICLE_ID_WIDTH = DEF_PARTICLE_ID_WIDTH,
    parameter int NUM_FILTER        = DEF_NUM_FILTER,
    parameter int DRAIN_GUARD       = DEF_DRAIN_GUARD
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 phase,
    input  logic [PARTICLE_ID_WIDTH:0]           home_count,
    input  logic [PARTICLE_ID_WIDTH:0]           nb_count,
    output logic                                 home_rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0]         home_rd_addr,
    input  logic [3*DATA_WIDTH-1:0]              home_rd_data,
    output logic                                 nb_rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0]         nb_rd_addr,
    input  logic [3*DATA_WIDTH-1:0]              nb_rd_data,
    input  logic [NUM_FILTER-1:0]                back_pressure,
    input  logic                                 all_buffer_empty,
    output logic [NUM_FILTER-1:0]                pair_valid,
    output logic [PARTICLE_ID_WIDTH-1:0]         ref_particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0]         nb_particle_id,
    output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_x,
    output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_y,
    output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_z,
    output logic [3*DATA_WIDTH-1:0]              nb_position,
    output logic                                 busy,
    output logic                                 done
);

    localparam int IW = PARTICLE_ID_WIDTH;
    localparam int CW = PARTICLE_ID_WIDTH + 1;     // count/base width, no wrap
    localparam int GW = $clog2(DRAIN_GUARD + 2);
    localparam logic [CW-1:0] NF_C    = CW'(NUM_FILTER);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [GW-1:0] GUARD_C = GW'(DRAIN_GUARD);

    pair_gen_state_e state_q, state_d;

    logic            phase_q;
    logic [CW-1:0]   home_cnt_q, nb_cnt_q, base_q;
    logic [CW-1:0]   ld_idx_q, ld_slot_q, nb_idx_q;
    logic            ld_vld_q, pres_vld_q;
    logic [IW-1:0]   nb_id_q;
    logic [GW-1:0]   dg_cnt_q;

    logic [CW-1:0]   rem, grp_n, base_nxt, home_addr_full;
    logic            load_issue, load_last, nb_issue, stream_last;
    logic            bp_block, guard_done, drain_exit;
    logic [NUM_FILTER-1:0] slot_valid, mask_in, ld_en;
    logic            mask_ld;

    // Slots in this group: NUM_FILTER, clipped by what is left of the home cell.
    assign rem            = home_cnt_q - base_q;
    assign grp_n          = (rem > NF_C) ? NF_C : rem;
    assign base_nxt       = base_q + NF_C;
    assign home_addr_full = base_q + ld_idx_q;

    assign load_issue  = (state_q == ST_LOAD) && (ld_idx_q < grp_n);
    assign load_last   = ld_vld_q && (ld_slot_q == grp_n - ONE_C);

    // Only back pressure on slots that can actually receive a pair stalls us.
    assign bp_block    = |(back_pressure & slot_valid);
    assign nb_issue    = (state_q == ST_STREAM) && (nb_idx_q < nb_cnt_q) && !bp_block;
    assign stream_last = pres_vld_q && ({1'b0, nb_id_q} == nb_cnt_q - ONE_C);

    assign guard_done  = (dg_cnt_q == GUARD_C);
    assign drain_exit  = (state_q == ST_DRAIN) && guard_done && all_buffer_empty;

    // Mask is latched on the first LOAD cycle; base is stable for the group.
    assign mask_ld = (state_q == ST_LOAD) && (ld_idx_q == '0);

    always_comb begin
        mask_in = '0;
        ld_en   = '0;
        for (int k = 0; k < NUM_FILTER; k++) begin
            mask_in[k] = (base_q + CW'(k)) < home_cnt_q;
            ld_en[k]   = ld_vld_q && (ld_slot_q == CW'(k));
        end
    end

    rl_ref_slot_bank #(
        .NUM_FILTER (NUM_FILTER),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slots (
        .clk        (clk),
        .rst        (rst),
        .mask_ld    (mask_ld),
        .mask_in    (mask_in),
        .ld_en      (ld_en),
        .ld_pos     (home_rd_data),
        .ref_x      (ref_x),
        .ref_y      (ref_y),
        .ref_z      (ref_z),
        .slot_valid (slot_valid)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (start)
                    state_d = (home_count == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:
                if (load_last)
                    state_d = (nb_cnt_q == '0) ? ST_DRAIN : ST_STREAM;
            ST_STREAM:
                if (stream_last)
                    state_d = ST_DRAIN;
            ST_DRAIN:
                if (drain_exit)
                    state_d = (base_nxt >= home_cnt_q) ? ST_DONE : ST_LOAD;
            ST_DONE:
                state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q    <= 1'b0;
            home_cnt_q <= '0;
            nb_cnt_q   <= '0;
            base_q     <= '0;
            ld_idx_q   <= '0;
            ld_slot_q  <= '0;
            ld_vld_q   <= 1'b0;
            nb_idx_q   <= '0;
            pres_vld_q <= 1'b0;
            nb_id_q    <= '0;
            dg_cnt_q   <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                phase_q    <= phase;
                home_cnt_q <= home_count;
                nb_cnt_q   <= nb_count;
                base_q     <= '0;
            end else if (drain_exit) begin
                base_q     <= base_nxt;
            end

            if (state_q != ST_LOAD)
                ld_idx_q <= '0;
            else if (load_issue)
                ld_idx_q <= ld_idx_q + ONE_C;

            // Home data arrives one cycle after the read; remember its slot.
            ld_vld_q  <= load_issue;
            ld_slot_q <= ld_idx_q;

            if (state_q != ST_STREAM)
                nb_idx_q <= '0;
            else if (nb_issue)
                nb_idx_q <= nb_idx_q + ONE_C;

            // An issued neighbour read is always presented, even if back
            // pressure rises meanwhile; the filters hold one spare entry.
            pres_vld_q <= nb_issue;
            if (nb_issue)
                nb_id_q <= nb_idx_q[IW-1:0];

            if (state_q != ST_DRAIN)
                dg_cnt_q <= '0;
            else if (!guard_done)
                dg_cnt_q <= dg_cnt_q + GW'(1);
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        home_rd_en      = load_issue;
        home_rd_addr    = load_issue ? home_addr_full[IW-1:0] : '0;
        nb_rd_en        = nb_issue;
        nb_rd_addr      = nb_issue ? nb_idx_q[IW-1:0] : '0;
        busy            = (state_q == ST_LOAD) || (state_q == ST_STREAM) ||
                          (state_q == ST_DRAIN);
        done            = (state_q == ST_DONE);
        ref_particle_id = base_q[IW-1:0];
        nb_particle_id  = pres_vld_q ? nb_id_q : '0;
        nb_position     = pres_vld_q ? nb_rd_data : '0;
        pair_valid      = '0;
        // Half-shell: in phase 0 a slot only pairs with higher neighbour ids.
        for (int k = 0; k < NUM_FILTER; k++)
            pair_valid[k] = pres_vld_q && slot_valid[k] &&
                            (phase_q || ({1'b0, nb_id_q} > (base_q + CW'(k))));
    end

endmodule

// File: tb/tb_rl_pair_gen.sv
module tb_rl_pair_gen;
    import rl_md_pkg::*;

    localparam int DW = 32;
    localparam int IW = 7;
    localparam int NF = 7;
    localparam int DG = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     start = 1'b0;
    logic                     phase = 1'b0;
    logic [IW:0]              home_count = '0;
    logic [IW:0]              nb_count = '0;
    logic                     home_rd_en, nb_rd_en;
    logic [IW-1:0]            home_rd_addr, nb_rd_addr;
    logic [3*DW-1:0]          home_rd_data = '0;
    logic [3*DW-1:0]          nb_rd_data = '0;
    logic [NF-1:0]            back_pressure = '0;
    logic                     all_buffer_empty = 1'b1;
    logic [NF-1:0]            pair_valid;
    logic [IW-1:0]            ref_particle_id, nb_particle_id;
    logic [NF-1:0][DW-1:0]    ref_x, ref_y, ref_z;
    logic [3*DW-1:0]          nb_position;
    logic                     busy, done;

    rl_pair_gen #(
        .DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(IW), .NUM_FILTER(NF), .DRAIN_GUARD(DG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .phase(phase),
        .home_count(home_count), .nb_count(nb_count),
        .home_rd_en(home_rd_en), .home_rd_addr(home_rd_addr), .home_rd_data(home_rd_data),
        .nb_rd_en(nb_rd_en), .nb_rd_addr(nb_rd_addr), .nb_rd_data(nb_rd_data),
        .back_pressure(back_pressure), .all_buffer_empty(all_buffer_empty),
        .pair_valid(pair_valid), .ref_particle_id(ref_particle_id),
        .nb_particle_id(nb_particle_id), .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z),
        .nb_position(nb_position), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            base;
        int            j;
        logic [NF-1:0] mask;
        logic [NF-1:0] smask;
    } exp_t;

    exp_t sbq[$];
    int   pcyc[$];
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, done_cnt = 0, home_reads = 0, nb_reads = 0, pairs_seen = 0;
    int   bp_pairs = 0, bp_reads = 0;
    logic bp_active = 1'b0;
    logic [NF-1:0] or_pv = '0;
    exp_t mon_e;

    function automatic logic [3*DW-1:0] hword(input int i);
        pos_t p;
        p.x = 32'h1000_0000 + 32'(i);
        p.y = 32'h2000_0000 + 32'(i);
        p.z = 32'h3000_0000 + 32'(i);
        return p;
    endfunction

    function automatic logic [3*DW-1:0] nword(input int i);
        pos_t p;
        p.x = 32'hA000_0000 + 32'(i);
        p.y = 32'hB000_0000 + 32'(i);
        p.z = 32'hC000_0000 + 32'(i);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Position memories: data valid the cycle after the read enable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (home_rd_en) home_rd_data <= hword(int'(home_rd_addr));
        if (nb_rd_en)   nb_rd_data   <= nword(int'(nb_rd_addr));
    end

    // Output monitor / scoreboard consumer, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (done)       done_cnt++;
            if (home_rd_en) home_reads++;
            if (nb_rd_en)   nb_reads++;
            if (bp_active && nb_rd_en) bp_reads++;
            if (pair_valid != '0) begin
                pairs_seen++;
                pcyc.push_back(cyc);
                or_pv = or_pv | pair_valid;
                if (bp_active) bp_pairs++;
                if (sbq.size() == 0) begin
                    chk("extra_pair", 128'(pair_valid), 128'(0));
                end else begin
                    mon_e = sbq.pop_front();
                    chk("pair_mask", 128'(pair_valid), 128'(mon_e.mask));
                    chk("nb_id", 128'(nb_particle_id), 128'(mon_e.j));
                    chk("ref_id", 128'(ref_particle_id), 128'(mon_e.base));
                    chk("nb_pos", 128'(nb_position), 128'(nword(mon_e.j)));
                    for (int k = 0; k < NF; k++)
                        if (mon_e.smask[k]) begin
                            chk("ref_x", 128'(ref_x[k]), 128'(hword(mon_e.base + k) & 96'hFFFF_FFFF));
                            chk("ref_z", 128'(ref_z[k]), 128'(hword(mon_e.base + k) >> 64));
                        end
                end
            end
        end
    end

    // Pushes the model's expected pairs, then pulses start.
    // Entered and left at #1 after a rising edge.
    task automatic start_pass(input logic ph, input int home, input int nb);
        exp_t e;
        for (int b = 0; b < home; b += NF)
            for (int j = 0; j < nb; j++) begin
                e.base = b; e.j = j; e.mask = '0; e.smask = '0;
                for (int k = 0; k < NF; k++)
                    if (b + k < home) begin
                        e.smask[k] = 1'b1;
                        if (ph || j > b + k) e.mask[k] = 1'b1;
                    end
                // A pair with no valid slot is invisible at the outputs.
                if (e.mask != '0) sbq.push_back(e);
            end
        phase      = ph;
        home_count = (IW+1)'(home);
        nb_count   = (IW+1)'(nb);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        phase      = ~ph;          // later changes must not matter
        home_count = '1;
        nb_count   = '1;
    endtask

    task automatic wait_done(input int limit);
        int d0 = done_cnt;
        int t  = 0;
        while (done_cnt == d0 && t < limit) begin
            @(posedge clk); #1; t++;
        end
        chk("done_seen", 128'(done_cnt != d0), 128'(1));
    endtask

    task automatic wait_pairs(input int n, input int limit);
        int t = 0;
        while (pairs_seen < n && t < limit) begin
            @(posedge clk); #1; t++;
        end
        chk("pairs_reached", 128'(pairs_seen >= n), 128'(1));
    endtask

    initial begin
        int d0, h0, n0, p0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_pv", 128'(pair_valid), 128'(0));
        chk("rst_rd", 128'({home_rd_en, nb_rd_en}), 128'(0));
        chk("rst_refid", 128'(ref_particle_id), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: full group, phase 1, three consecutive pairs
        pcyc.delete(); d0 = done_cnt;
        start_pass(1'b1, 7, 3);
        chk("t1_busy", 128'(busy), 128'(1));
        wait_done(200);
        chk("t1_npairs", 128'(pcyc.size()), 128'(3));
        if (pcyc.size() == 3) chk("t1_consec", 128'(pcyc[2] - pcyc[0]), 128'(2));
        chk("t1_done_cnt", 128'(done_cnt - d0), 128'(1));
        chk("t1_sb_empty", 128'(sbq.size()), 128'(0));
        @(posedge clk); #1;
        chk("t1_idle_busy", 128'(busy), 128'(0));

        // 2: half-shell filtering
        or_pv = '0;
        start_pass(1'b0, 3, 3);
        wait_done(200);
        chk("t2_slots_used", 128'(or_pv), 128'(7'b0000011));
        chk("t2_sb_empty", 128'(sbq.size()), 128'(0));

        // 3: two groups, one done
        d0 = done_cnt; h0 = home_reads; p0 = pairs_seen;
        start_pass(1'b1, 10, 2);
        wait_done(300);
        chk("t3_home_reads", 128'(home_reads - h0), 128'(10));
        chk("t3_pairs", 128'(pairs_seen - p0), 128'(4));
        chk("t3_done_cnt", 128'(done_cnt - d0), 128'(1));
        chk("t3_sb_empty", 128'(sbq.size()), 128'(0));

        // 4: back pressure mid-stream
        n0 = nb_reads; p0 = pairs_seen;
        start_pass(1'b1, 7, 20);
        wait_pairs(p0 + 5, 200);
        bp_pairs = 0; bp_reads = 0;
        back_pressure = 7'b0000100; bp_active = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        back_pressure = '0; bp_active = 1'b0;
        chk("t4_bp_pairs_le1", 128'(bp_pairs <= 1), 128'(1));
        chk("t4_bp_reads", 128'(bp_reads), 128'(0));
        wait_done(300);
        chk("t4_nb_reads", 128'(nb_reads - n0), 128'(20));
        chk("t4_sb_empty", 128'(sbq.size()), 128'(0));

        // 5a: drain waits on all_buffer_empty
        all_buffer_empty = 1'b0;
        p0 = pairs_seen; h0 = home_reads;
        start_pass(1'b1, 10, 2);
        wait_pairs(p0 + 2, 200);
        n0 = home_reads;
        repeat (20) begin @(posedge clk); #1; end
        chk("t5_no_load", 128'(home_reads), 128'(n0));
        chk("t5_busy", 128'(busy), 128'(1));
        all_buffer_empty = 1'b1;
        wait_done(300);
        chk("t5_home_reads", 128'(home_reads - h0), 128'(10));
        chk("t5_sb_empty", 128'(sbq.size()), 128'(0));

        // 5b: empty home cell
        d0 = done_cnt; h0 = home_reads; n0 = nb_reads;
        start_pass(1'b1, 0, 5);
        @(posedge clk); #1;
        chk("t5b_done", 128'(done_cnt - d0), 128'(1));
        chk("t5b_reads", 128'((home_reads - h0) + (nb_reads - n0)), 128'(0));

        // 6: reset mid-stream, then a clean pass
        p0 = pairs_seen;
        start_pass(1'b1, 7, 30);
        wait_pairs(p0 + 3, 200);
        rst = 1'b0;
        sbq.delete();
        #1;
        chk("t6_pv", 128'(pair_valid), 128'(0));
        chk("t6_rd", 128'({home_rd_en, nb_rd_en}), 128'(0));
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_ref_x", 128'(|ref_x), 128'(0));
        chk("t6_nb_pos", 128'(nb_position), 128'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        pcyc.delete(); d0 = done_cnt;
        start_pass(1'b1, 7, 3);
        wait_done(200);
        chk("t6_npairs", 128'(pcyc.size()), 128'(3));
        chk("t6_done_cnt", 128'(done_cnt - d0), 128'(1));
        chk("t6_sb_empty", 128'(sbq.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
